// File: rtl/video_sram_port_arbiter.sv
// Arbitrates one SRAM primary port between requester A (bus) and B (blitter); ack 3 cycles after req in IDLE, one access per 4 cycles.
// No backpressure path: a losing requester simply stays busy until its own ack pulse.
module video_sram_port_arbiter #(
   parameter int SRAM_ADDRESS_SIZE = 10
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         fixedPriority,
   input  logic                         a_req,
   input  logic                         a_we,
   input  logic [3:0]                   a_mask,
   input  logic [SRAM_ADDRESS_SIZE-1:0] a_addr,
   input  logic [31:0]                  a_wdata,
   output logic                         a_busy,
   output logic                         a_ack,
   output logic [31:0]                  a_rdata,
   input  logic                         b_req,
   input  logic                         b_we,
   input  logic [3:0]                   b_mask,
   input  logic [SRAM_ADDRESS_SIZE-1:0] b_addr,
   input  logic [31:0]                  b_wdata,
   output logic                         b_busy,
   output logic                         b_ack,
   output logic [31:0]                  b_rdata,
   output logic                         sram_select,
   output logic                         sram_writeEnable,
   output logic [3:0]                   sram_writeMask,
   output logic [SRAM_ADDRESS_SIZE-1:0] sram_address,
   output logic [31:0]                  sram_dataWrite,
   input  logic [31:0]                  sram_dataRead
);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

   state_t state, state_nxt;
   logic   owner_b;
   logic   owner_we;
   logic   last_a;
   logic   grant_b;

   assign a_busy = a_req & ~a_ack;
   assign b_busy = b_req & ~b_ack;

   always_comb begin
      state_nxt = state;
      grant_b   = 1'b0;
      case (state)
         IDLE: begin
            if (a_req || b_req) begin
               state_nxt = ISSUE;
               // On a tie, round-robin hands the grant to whoever did not go last.
               if (a_req && b_req) grant_b = !fixedPriority && last_a;
               else                grant_b = b_req;
            end
         end
         ISSUE:   state_nxt = CAPTURE;
         CAPTURE: state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state            <= IDLE;
         owner_b          <= 1'b0;
         owner_we         <= 1'b0;
         last_a           <= 1'b0;
         a_ack            <= 1'b0;
         b_ack            <= 1'b0;
         a_rdata          <= '0;
         b_rdata          <= '0;
         sram_select      <= 1'b0;
         sram_writeEnable <= 1'b0;
         sram_writeMask   <= '0;
         sram_address     <= '0;
         sram_dataWrite   <= '0;
      end else begin
         state            <= state_nxt;
         sram_select      <= (state_nxt == ISSUE);
         sram_writeEnable <= 1'b0;
         a_ack            <= 1'b0;
         b_ack            <= 1'b0;
         case (state)
            IDLE: begin
               if (state_nxt == ISSUE) begin
                  owner_b          <= grant_b;
                  owner_we         <= grant_b ? b_we : a_we;
                  sram_writeEnable <= grant_b ? b_we : a_we;
                  sram_writeMask   <= grant_b ? b_mask : a_mask;
                  sram_address     <= grant_b ? b_addr : a_addr;
                  sram_dataWrite   <= grant_b ? b_wdata : a_wdata;
               end
            end
            CAPTURE: begin
               if (!owner_we) begin
                  if (owner_b) b_rdata <= sram_dataRead;
                  else         a_rdata <= sram_dataRead;
               end
               a_ack <= !owner_b;
               b_ack <= owner_b;
            end
            DONE:    last_a <= !owner_b;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_video_sram_port_arbiter.sv
// Scoreboarded bench for video_sram_port_arbiter with a word-level SRAM model and grant-order reference.
module tb_video_sram_port_arbiter;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          fixedPriority;
   logic          a_req, a_we, b_req, b_we;
   logic [3:0]    a_mask, b_mask;
   logic [AW-1:0] a_addr, b_addr;
   logic [31:0]   a_wdata, b_wdata;
   logic          a_busy, a_ack, b_busy, b_ack;
   logic [31:0]   a_rdata, b_rdata;
   logic          sram_select, sram_writeEnable;
   logic [3:0]    sram_writeMask;
   logic [AW-1:0] sram_address;
   logic [31:0]   sram_dataWrite;
   logic [31:0]   sram_dataRead;

   always #5 clk = ~clk;

   video_sram_port_arbiter #(.SRAM_ADDRESS_SIZE(AW)) dut (
      .clk(clk), .rst_n(rst_n), .fixedPriority(fixedPriority),
      .a_req(a_req), .a_we(a_we), .a_mask(a_mask), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_busy(a_busy), .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_mask(b_mask), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_busy(b_busy), .b_ack(b_ack), .b_rdata(b_rdata),
      .sram_select(sram_select), .sram_writeEnable(sram_writeEnable),
      .sram_writeMask(sram_writeMask), .sram_address(sram_address),
      .sram_dataWrite(sram_dataWrite), .sram_dataRead(sram_dataRead)
   );

   typedef struct packed {
      logic [31:0]   cyc;
      logic          we;
      logic [3:0]    mask;
      logic [AW-1:0] addr;
      logic [31:0]   wdata;
   } iss_t;

   typedef struct packed {
      logic [31:0] cyc;
      logic        port_b;
      logic [31:0] rdata;
   } ack_t;

   typedef struct {
      bit          ok;
      string       name;
      logic [31:0] act;
      logic [31:0] exp;
   } chk_t;

   iss_t iq[$];
   ack_t aq[$];
   chk_t cq[$];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit mon_en   = 1'b0;

   logic [31:0] model_mem [0:1023];
   logic        model_last_a;
   logic [31:0] model_rd_a, model_rd_b;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] m);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
      return r;
   endfunction

   function automatic logic [31:0] init_word(input int i);
      logic [31:0] v;
      v = 32'(i) * 32'h9E37_79B9 ^ 32'h5A5A_0F0F;
      if (i == 5) v = 32'hDEAD_BEEF;
      return v;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural SRAM: read data appears the cycle after select.
   initial begin
      logic [31:0] sram_mem [0:1023];
      for (int i = 0; i < 1024; i++) sram_mem[i] = init_word(i);
      sram_dataRead = '0;
      forever begin
         @(posedge clk);
         if (sram_select) begin
            if (sram_writeEnable)
               sram_mem[sram_address] = merge(sram_mem[sram_address], sram_dataWrite, sram_writeMask);
            else
               sram_dataRead <= sram_mem[sram_address];
         end
      end
   end

   task automatic do_chk(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic req_chk(input bit ok, input string name, input logic [31:0] act,
                          input logic [31:0] exp);
      chk_t c;
      c.ok = ok; c.name = name; c.act = act; c.exp = exp;
      cq.push_back(c);
   endtask

   always @(negedge clk) begin
      iss_t  e;
      ack_t  k;
      chk_t  c;
      logic [31:0] rd;
      while (cq.size() > 0) begin
         c = cq.pop_front();
         do_chk(c.ok, c.name, c.act, c.exp);
      end
      if (mon_en) begin
         if (sram_select) begin
            if (iq.size() == 0) do_chk(1'b0, "unexpected_select", 32'(sram_address), 32'(0));
            else begin
               e = iq.pop_front();
               do_chk(32'(cyc) == e.cyc, "issue_cycle", 32'(cyc), e.cyc);
               do_chk(sram_writeEnable == e.we, "issue_we", 32'(sram_writeEnable), 32'(e.we));
               do_chk(sram_address == e.addr, "issue_addr", 32'(sram_address), 32'(e.addr));
               if (e.we) begin
                  do_chk(sram_writeMask == e.mask, "issue_mask", 32'(sram_writeMask), 32'(e.mask));
                  do_chk(sram_dataWrite == e.wdata, "issue_wdata", sram_dataWrite, e.wdata);
               end
            end
         end else begin
            do_chk(sram_writeEnable == 1'b0, "we_outside_issue", 32'(sram_writeEnable), 32'(0));
         end
         if (a_ack && b_ack) do_chk(1'b0, "double_ack", 32'(2), 32'(1));
         else if (a_ack || b_ack) begin
            if (aq.size() == 0) do_chk(1'b0, "unexpected_ack", 32'(b_ack), 32'(0));
            else begin
               k  = aq.pop_front();
               rd = k.port_b ? b_rdata : a_rdata;
               do_chk(b_ack == k.port_b, "ack_port_b", 32'(b_ack), 32'(k.port_b));
               do_chk(32'(cyc) == k.cyc, "ack_cycle", 32'(cyc), k.cyc);
               do_chk(rd == k.rdata, "ack_rdata", rd, k.rdata);
            end
         end
      end
   end

   // Reference: records one access in grant order, updating the word-level memory image.
   task automatic push_access(input logic pb, input int ic);
      iss_t e;
      ack_t k;
      e.cyc   = 32'(ic);
      e.we    = pb ? b_we : a_we;
      e.mask  = pb ? b_mask : a_mask;
      e.addr  = pb ? b_addr : a_addr;
      e.wdata = pb ? b_wdata : a_wdata;
      iq.push_back(e);
      if (e.we) model_mem[e.addr] = merge(model_mem[e.addr], e.wdata, e.mask);
      else if (pb) model_rd_b = model_mem[e.addr];
      else model_rd_a = model_mem[e.addr];
      k.cyc    = 32'(ic + 2);
      k.port_b = pb;
      k.rdata  = pb ? model_rd_b : model_rd_a;
      aq.push_back(k);
      model_last_a = !pb;
   endtask

   // held>0: both requesters keep req up until that many accesses have completed.
   task automatic run_round(input bit ua, input bit ub, input bit fp, input int held,
                            input bit drop_early);
      bit   pa, pbn;
      logic w;
      int   n, got, c0, budget;
      fixedPriority = fp;
      pa  = ua;
      pbn = ub;
      n   = (held > 0) ? held : (int'(ua) + int'(ub));
      c0  = cyc;
      for (int k = 0; k < n; k++) begin
         if (pa && pbn) w = fp ? 1'b0 : model_last_a;
         else           w = pbn;
         push_access(w, c0 + 1 + 4 * k);
         if (held == 0) begin
            if (w) pbn = 1'b0;
            else   pa  = 1'b0;
         end
      end
      a_req  = ua;
      b_req  = ub;
      got    = 0;
      budget = 4 * n + 12;
      while (got < n && budget > 0) begin
         @(posedge clk); #1;
         budget--;
         if (drop_early && cyc == c0 + 2) a_req = 1'b0;
         if (held > 0 && fp && ub) req_chk(b_busy == 1'b1, "b_busy_starved", 32'(b_busy), 32'(1));
         if (a_ack) begin got++; if (held == 0) a_req = 1'b0; end
         if (b_ack) begin got++; if (held == 0) b_req = 1'b0; end
         if (held > 0 && got == n) begin a_req = 1'b0; b_req = 1'b0; end
      end
      req_chk(got == n, "round_ack_count", 32'(got), 32'(n));
      a_req = 1'b0;
      b_req = 1'b0;
      repeat (6) @(posedge clk);
      #1;
   endtask

   initial begin
      iss_t e;
      int   pat;
      rst_n = 1'b0; fixedPriority = 1'b0;
      a_req = 1'b0; a_we = 1'b0; a_mask = '0; a_addr = '0; a_wdata = '0;
      b_req = 1'b0; b_we = 1'b0; b_mask = '0; b_addr = '0; b_wdata = '0;
      for (int i = 0; i < 1024; i++) model_mem[i] = init_word(i);
      model_last_a = 1'b0;
      model_rd_a   = '0;
      model_rd_b   = '0;

      repeat (3) @(posedge clk);
      #1;
      req_chk(sram_select == 1'b0, "rst_select", 32'(sram_select), 32'(0));
      req_chk(sram_writeEnable == 1'b0, "rst_we", 32'(sram_writeEnable), 32'(0));
      req_chk(sram_writeMask == 4'd0, "rst_mask", 32'(sram_writeMask), 32'(0));
      req_chk(sram_address == '0, "rst_addr", 32'(sram_address), 32'(0));
      req_chk(sram_dataWrite == 32'd0, "rst_wdata", sram_dataWrite, 32'(0));
      req_chk(a_ack == 1'b0 && b_ack == 1'b0, "rst_acks", 32'({a_ack, b_ack}), 32'(0));
      req_chk(a_rdata == 32'd0, "rst_a_rdata", a_rdata, 32'(0));
      req_chk(b_rdata == 32'd0, "rst_b_rdata", b_rdata, 32'(0));
      rst_n  = 1'b1;
      mon_en = 1'b1;
      @(posedge clk); #1;

      // Simultaneous A and B right after reset under round-robin.
      a_we = 1'b0; a_addr = 10'h010;
      b_we = 1'b0; b_addr = 10'h020;
      run_round(1'b1, 1'b1, 1'b0, 0, 1'b0);

      // A read of the preloaded word.
      a_we = 1'b0; a_addr = 10'h005;
      run_round(1'b1, 1'b0, 1'b0, 0, 1'b0);

      // B partial write at the top address.
      b_we = 1'b1; b_addr = 10'h3FF; b_mask = 4'b0011; b_wdata = 32'h1234_5678;
      run_round(1'b0, 1'b1, 1'b0, 0, 1'b0);

      // Both held: alternation, then A-only service under fixed priority.
      a_we = 1'b0; a_addr = 10'h3FF;
      b_we = 1'b1; b_addr = 10'h100; b_mask = 4'b1111; b_wdata = 32'hCAFE_F00D;
      run_round(1'b1, 1'b1, 1'b0, 8, 1'b0);
      run_round(1'b1, 1'b1, 1'b1, 8, 1'b0);

      // Zero-mask write still completes.
      a_we = 1'b1; a_addr = 10'h100; a_mask = 4'b0000; a_wdata = 32'hFFFF_FFFF;
      run_round(1'b1, 1'b0, 1'b0, 0, 1'b0);
      a_we = 1'b0;
      run_round(1'b1, 1'b0, 1'b0, 0, 1'b0);

      // Reset asserted while the access is in ISSUE: it must vanish without an ack.
      a_we = 1'b0; a_addr = 10'h005;
      e.cyc = 32'(cyc + 1); e.we = 1'b0; e.mask = a_mask; e.addr = a_addr; e.wdata = a_wdata;
      iq.push_back(e);
      a_req = 1'b1;
      @(posedge clk); #1;
      req_chk(sram_select == 1'b1, "rst_mid_select_before", 32'(sram_select), 32'(1));
      rst_n = 1'b0;
      a_req = 1'b0;
      @(posedge clk); #1;
      req_chk(sram_select == 1'b0, "rst_mid_select_after", 32'(sram_select), 32'(0));
      req_chk(a_rdata == 32'd0, "rst_mid_a_rdata", a_rdata, 32'(0));
      rst_n = 1'b1;
      model_last_a = 1'b0;
      model_rd_a   = '0;
      model_rd_b   = '0;
      repeat (8) @(posedge clk);
      #1;

      // Requester drops req mid-access.
      a_we = 1'b0; a_addr = 10'h020;
      run_round(1'b1, 1'b0, 1'b0, 0, 1'b1);

      for (int r = 0; r < 60; r++) begin
         a_we = 1'($urandom_range(1)); a_mask = 4'($urandom); a_addr = AW'($urandom_range(15));
         a_wdata = $urandom;
         b_we = 1'($urandom_range(1)); b_mask = 4'($urandom); b_addr = AW'($urandom_range(15));
         b_wdata = $urandom;
         pat = $urandom_range(1, 3);
         if (pat == 3 && $urandom_range(7) == 0)
            run_round(1'b1, 1'b1, 1'($urandom_range(1)), $urandom_range(2, 5), 1'b0);
         else
            run_round(pat[0], pat[1], 1'($urandom_range(1)), 0, 1'b0);
      end

      req_chk(iq.size() == 0, "issue_queue_drained", 32'(iq.size()), 32'(0));
      req_chk(aq.size() == 0, "ack_queue_drained", 32'(aq.size()), 32'(0));
      @(negedge clk);
      @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
